// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding and limits for the toggle-handshake CDC source
package cdc_pkg;
    typedef enum logic {IDLE, WAIT_ACK} state_t;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
endpackage

// File: rtl/sync_nff_bit.sv
// sync_nff_bit: single-bit STAGES-deep flop synchronizer, sync reset to 0
module sync_nff_bit #(
    parameter int STAGES = 2
) (
    input  logic clkin,
    input  logic rst_in,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clkin)
        if (rst_in) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: two-phase req/ack CDC source controller; CDC_TIMEOUT_EN adds a sticky ack watchdog
module cdc_handshake_tx import cdc_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic             clkin,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] s_data_in,
    input  logic             s_valid_in,
    output logic             s_ready_out,
    output logic [WIDTH-1:0] xfer_data_out,
    output logic             xfer_req_out,
    input  logic             xfer_ack_in,
    output logic             busy_out,
    output logic             done_out
`ifdef CDC_TIMEOUT_EN
    ,
    output logic             timeout_err_out
`endif
);
    state_t state, state_nxt;
    logic ack_sync, accept, complete;
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("SYNC_STAGES out of range 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end
    sync_nff_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clkin(clkin),
        .rst_in(rst_in),
        .d(xfer_ack_in),
        .q(ack_sync)
    );
    always_comb begin
        s_ready_out = (state == IDLE);
        busy_out = (state == WAIT_ACK);
        accept = s_ready_out && s_valid_in;
        // level compare, so a duplicate ack toggle seen in IDLE is harmless
        complete = busy_out && (ack_sync == xfer_req_out);
        state_nxt = accept ? WAIT_ACK : complete ? IDLE : state;
    end
    always_ff @(posedge clkin) begin
        if (rst_in) begin
            state <= IDLE;
            xfer_data_out <= '0;
            xfer_req_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state <= state_nxt;
            done_out <= complete;
            if (accept) begin
                xfer_data_out <= s_data_in;
                xfer_req_out <= ~xfer_req_out;
            end
        end
    end
`ifdef CDC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge clkin) begin
        if (rst_in) begin
            wait_cnt <= '0;
            timeout_err_out <= 1'b0;
        end else begin
            if (accept) wait_cnt <= '0;
            else if (busy_out && wait_cnt != CW'(TIMEOUT_CYCLES)) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CW'(TIMEOUT_CYCLES)) timeout_err_out <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed bench with a cycle-level behavioural model and literal pins
module tb_cdc_handshake_tx;
    localparam int W = 8;
    localparam int S = 2;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] din = '0;
    logic valid = 1'b0;
    logic ack = 1'b0;
    logic ready, req, busy, done;
    logic [W-1:0] xdata;
`ifdef CDC_TIMEOUT_EN
    logic terr;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    cdc_handshake_tx #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
        .clkin(clk),
        .rst_in(rst),
        .s_data_in(din),
        .s_valid_in(valid),
        .s_ready_out(ready),
        .xfer_data_out(xdata),
        .xfer_req_out(req),
        .xfer_ack_in(ack),
        .busy_out(busy),
        .done_out(done)
`ifdef CDC_TIMEOUT_EN
        ,
        .timeout_err_out(terr)
`endif
    );
    always #5 clk = ~clk;
    // model: a transfer is pending until the ack level seen S edges late matches the req level
    logic m_busy = 1'b0, m_req = 1'b0, m_done = 1'b0, started = 1'b0;
    logic [W-1:0] m_data = '0;
    logic hist [S];
    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_busy = 1'b0; m_req = 1'b0; m_done = 1'b0; m_data = '0;
            for (int i = 0; i < S; i++) hist[i] = 1'b0;
        end else begin
            m_done = m_busy && (hist[S-1] == m_req);
            if (m_busy) m_busy = !m_done;
            else if (valid) begin
                m_data = din; m_req = !m_req; m_busy = 1'b1;
            end
            for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ack;
        end
    end
    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (started) begin
        cmp("model_ready", int'(ready), int'(!m_busy));
        cmp("model_busy", int'(busy), int'(m_busy));
        cmp("model_req", int'(req), int'(m_req));
        cmp("model_data", int'(xdata), int'(m_data));
        cmp("model_done", int'(done), int'(m_done));
    end
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < S; i++) hist[i] = 1'b0;
        step(3);
        cmp("rst_ready", int'(ready), 1);
        cmp("rst_req", int'(req), 0);
        cmp("rst_data", int'(xdata), 0);
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_done", int'(done), 0);
        rst = 1'b0;
        step(2);
        valid = 1'b1; din = 8'hA5;
        step(1);
        valid = 1'b0; din = 8'h00;
        cmp("acc_data", int'(xdata), 'hA5);
        cmp("acc_req", int'(req), 1);
        cmp("acc_busy", int'(busy), 1);
        cmp("acc_ready", int'(ready), 0);
        step(8);
        ack = 1'b1;
        step(2);
        cmp("lat_done_early", int'(done), 0);
        cmp("lat_busy_early", int'(busy), 1);
        step(1);
        cmp("lat_done", int'(done), 1);
        cmp("lat_ready", int'(ready), 1);
        step(1);
        cmp("done_one_cycle", int'(done), 0);
        valid = 1'b1; din = 8'h5A;
        step(1);
        cmp("acc2_req", int'(req), 0);
        din = 8'h3C;
        step(4);
        cmp("hold_data", int'(xdata), 'h5A);
        cmp("hold_busy", int'(busy), 1);
        ack = 1'b0;
        step(3);
        cmp("same_cycle_done", int'(done), 1);
        cmp("same_cycle_noacc", int'(xdata), 'h5A);
        step(1);
        valid = 1'b0;
        cmp("late_acc_data", int'(xdata), 'h3C);
        cmp("late_acc_req", int'(req), 1);
        ack = 1'b1;
        step(5);
        ack = 1'b0;
        step(1);
        ack = 1'b1;
        step(6);
        cmp("spur_ready", int'(ready), 1);
        cmp("spur_req", int'(req), 1);
        cmp("spur_data", int'(xdata), 'h3C);
        valid = 1'b1; din = 8'h77;
        step(1);
        valid = 1'b0;
        step(1);
        rst = 1'b1; ack = 1'b0;
        step(1);
        cmp("mid_rst_req", int'(req), 0);
        cmp("mid_rst_data", int'(xdata), 0);
        cmp("mid_rst_ready", int'(ready), 1);
        rst = 1'b0;
        step(1);
        valid = 1'b1; din = 8'h11;
        step(1);
        valid = 1'b0;
        cmp("post_rst_data", int'(xdata), 'h11);
        cmp("post_rst_req", int'(req), 1);
        ack = 1'b1;
        step(3);
        cmp("post_rst_done", int'(done), 1);
`ifdef CDC_TIMEOUT_EN
        cmp("to_clear", int'(terr), 0);
        step(1);
        valid = 1'b1; din = 8'h99;
        step(1);
        valid = 1'b0;
        step(10);
        cmp("to_early", int'(terr), 0);
        step(10);
        cmp("to_set", int'(terr), 1);
        step(5);
        cmp("to_sticky", int'(terr), 1);
        ack = 1'b0;
        step(3);
        cmp("to_late_done", int'(done), 1);
        cmp("to_still", int'(terr), 1);
`endif
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
